reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 105 ++++++++++
 tb/tb_reg_file_mp.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a self-running init sequence after reset or clear.
// Reads are combinational with write-through bypass; dropped writes raise a one-cycle wr_err.
module reg_file_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       wr_err
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {INIT, READY} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
    logic                wr_err_q, wr_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   init_val;
    logic                wr_ok;

    assign init_val = (INIT_MODE != 0) ? DATA_W'(init_ptr_q) : '0;
    assign wr_ok    = (state_q == READY) && wr_en && !clr_req &&
                      !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        wr_err_d   = 1'b0;
        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                wr_err_d   = wr_en;
                if (init_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                // Clear wins over a simultaneous write, which is then reported as dropped
                if (clr_req) begin
                    state_d    = INIT;
                    init_ptr_d = '0;
                    wr_err_d   = wr_en;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == INIT) begin
            mem_d[init_ptr_q] = init_val;
        end else if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Array has no reset; the init sequence rewrites every entry
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (state_q == INIT)                   return '0;
        if ((ZERO_REG != 0) && (a == '0))      return '0;
        if (wr_ok && (a == wr_addr))           return wr_data;
        return mem_q[a];
    endfunction

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = read_port(rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    assign busy   = (state_q == INIT);
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp against an array-based reference model, plus directed
// scenarios for bypass, register zero, clear, reset mid-sequence and a 4-port zero-init instance.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic        wr_err;

    logic [19:0]  rd_addr2;
    logic [127:0] rd_data2;
    logic         wr_en2;
    logic [4:0]   wr_addr2;
    logic [31:0]  wr_data2;
    logic         clr_req2;
    logic         busy2;
    logic         wr_err2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_mem [32];
    bit          m_busy;
    int          m_cnt;
    bit          m_err;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
    );

    reg_file_mp #(.NUM_RD(4), .INIT_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .clr_req(clr_req2), .busy(busy2), .wr_err(wr_err2)
    );

    // Expected combinational read for the default instance, from the model's view of the array
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (m_busy || a == 5'd0) return 32'd0;
        if (wr_en && !clr_req && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        m_busy = 1'b1;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    // Advance one rising edge and update the model from the inputs held across it
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else if (m_busy) begin
            m_mem[m_cnt] = 32'(m_cnt);
            m_cnt++;
            if (m_cnt == 32) m_busy = 1'b0;
            m_err = wr_en;
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_err  = wr_en;
        end else begin
            m_err = 1'b0;
            if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; rd_addr = '0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; clr_req2 = 1'b0; rd_addr2 = '0;
        model_reset();
        #1;
        tests_run++;
        if (busy !== 1'b1 || wr_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: busy=%b wr_err=%b expected busy=1 wr_err=0", busy, wr_err);
        end
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            rd_addr = 10'($urandom);
            #1;
            tests_run++;
            if (rd_data !== 64'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_busy_read: got %h expected 0", rd_data);
            end
            step();
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("[TB] FAIL reset_init_edges: got %0d expected 32", n);
        end
        rd_addr = {5'd3, 5'd5};
        #1;
        tests_run++;
        if (rd_data !== {32'd3, 32'd5}) begin
            tests_failed++;
            $display("[TB] FAIL init_values: got %h expected %h", rd_data, {32'd3, 32'd5});
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr = {5'd3, 5'd7};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== exp_rd(5'd3)) begin
            tests_failed++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected %h_deadbeef", rd_data, exp_rd(5'd3));
        end
        step();
        tests_run++;
        if (wr_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bypass_wr_err: got %b expected 0", wr_err);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL bypass_next_cycle: got %h expected deadbeef", rd_data[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
        #1;
        tests_run++;
        if (rd_data !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL zero_reg_bypass: got %h expected 0", rd_data);
        end
        step();
        tests_run++;
        if (wr_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_reg_wr_err: got %b expected 0", wr_err);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        tests_run++;
        if (rd_data !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL zero_reg_read: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_clear_with_write();
        int n;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = $urandom; clr_req = 1'b1; rd_addr = {5'd9, 5'd9};
        #1;
        tests_run++;
        if (rd_data[31:0] !== exp_rd(5'd9)) begin
            tests_failed++;
            $display("[TB] FAIL clear_no_bypass: got %h expected %h", rd_data[31:0], exp_rd(5'd9));
        end
        step();
        tests_run++;
        if (wr_err !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clear_drop: wr_err=%b busy=%b expected 1 1", wr_err, busy);
        end
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            clr_req = (n == 5);
            wr_en   = (n == 7);
            rd_addr = 10'($urandom);
            #1;
            tests_run++;
            if (rd_data !== 64'd0) begin
                tests_failed++;
                $display("[TB] FAIL clear_busy_read: got %h expected 0", rd_data);
            end
            step();
            n++;
            tests_run++;
            if (wr_err !== m_err || busy !== m_busy) begin
                tests_failed++;
                $display("[TB] FAIL clear_seq: step %0d wr_err=%b busy=%b expected %b %b", n, wr_err, busy, m_err, m_busy);
            end
            @(negedge clk);
        end
        wr_en = 1'b0; clr_req = 1'b0;
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("[TB] FAIL clear_busy_len: got %0d expected 32", n);
        end
        rd_addr = {5'd0, 5'd9};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'd9) begin
            tests_failed++;
            $display("[TB] FAIL clear_reg9: got %h expected 9", rd_data[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clr_req = 1'b1;
        step();
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) begin
            step();
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (busy !== 1'b1 || wr_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_init_reset: busy=%b wr_err=%b expected 1 0", busy, wr_err);
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            rd_addr = 10'($urandom);
            #1;
            tests_run++;
            if (rd_data !== 64'd0) begin
                tests_failed++;
                $display("[TB] FAIL mid_init_busy_read: got %h expected 0", rd_data);
            end
            step();
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("[TB] FAIL mid_init_edges: got %0d expected 32", n);
        end
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFEF00D;
        #1;
        rst = 1'b0;
        model_reset();
        step();
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            @(negedge clk);
        end
        rd_addr = {5'd12, 5'd12};
        #1;
        tests_run++;
        if (n != 32 || rd_data[31:0] !== 32'd12) begin
            tests_failed++;
            $display("[TB] FAIL mid_write_reset: edges=%0d reg12=%h expected 32 and c", n, rd_data[31:0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            clr_req = ($urandom_range(0, 59) == 0);
            rd_addr[4:0] = 5'($urandom);
            rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (rd_data[k*32 +: 32] !== exp_rd(rd_addr[k*5 +: 5])) begin
                    tests_failed++;
                    $display("[TB] FAIL random_read: cycle %0d port %0d addr %0d got %h expected %h",
                             i, k, rd_addr[k*5 +: 5], rd_data[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5]));
                end
            end
            step();
            tests_run++;
            if (busy !== m_busy || wr_err !== m_err) begin
                tests_failed++;
                $display("[TB] FAIL random_status: cycle %0d busy=%b wr_err=%b expected %b %b",
                         i, busy, wr_err, m_busy, m_err);
            end
            @(negedge clk);
        end
        wr_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic test_four_ports();
        tests_run++;
        if (busy2 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL four_port_ready: busy=%b expected 0", busy2);
        end
        wr_en2 = 1'b1; wr_addr2 = 5'd2; wr_data2 = 32'hA5; rd_addr2 = {4{5'd2}};
        #1;
        tests_run++;
        if (rd_data2 !== {4{32'hA5}}) begin
            tests_failed++;
            $display("[TB] FAIL four_port_bypass: got %h expected all a5", rd_data2);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (wr_err2 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL four_port_wr_err: got %b expected 0", wr_err2);
        end
        @(negedge clk);
        wr_en2 = 1'b0;
        #1;
        tests_run++;
        if (rd_data2 !== {4{32'hA5}}) begin
            tests_failed++;
            $display("[TB] FAIL four_port_read: got %h expected all a5", rd_data2);
        end
        rd_addr2 = {5'd17, 5'd3, 5'd2, 5'd3};
        #1;
        tests_run++;
        if (rd_data2 !== {32'd0, 32'd0, 32'hA5, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL four_port_zero_init: got %h expected 0_0_a5_0", rd_data2);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_clear_with_write();
        test_reset_mid();
        test_random();
        test_four_ports();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
